wb_interconnect_nxm: RTL and testbench



---
 rtl/wb_interconnect_nxm.sv | 267 ++++++++++++++++++++++++++
 tb/tb_wb_interconnect_nxm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_nxm.sv
// wb_interconnect_nxm: parametrised Wishbone crossbar, N_MASTERS masters to N_SLAVES slaves.
// Each master runs a small FSM that latches the decoded target for the whole bus cycle.
// Each target, including an internal decode-error target at index N_SLAVES, has a
// round-robin arbiter that holds its grant until the grantee's cycle ends.
// An optional per-slave watchdog terminates stalled transfers with an error.
//
// Ports (per-channel signals are packed, channel k in slice k):
//   clk, rst          clock, synchronous active-high reset
//   m_adr .. m_we     master request inputs
//   m_dat_r, m_ack,
//   m_err             master response outputs; zero unless the master is in its data phase
//   s_adr .. s_we     slave request outputs; zero unless the slave is granted
//   s_dat_r, s_ack,
//   s_err             slave response inputs
module wb_interconnect_nxm #(
   parameter int unsigned N_MASTERS      = 2,
   parameter int unsigned N_SLAVES       = 3,
   parameter int unsigned WB_ADDR_WIDTH  = 32,
   parameter int unsigned WB_DATA_WIDTH  = 32,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE  = '0,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = '0,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
   input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
   input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
   input  logic [N_MASTERS*3-1:0]                 m_cti,
   input  logic [N_MASTERS*2-1:0]                 m_bte,
   input  logic [N_MASTERS-1:0]                   m_cyc,
   input  logic [N_MASTERS-1:0]                   m_stb,
   input  logic [N_MASTERS-1:0]                   m_we,
   output logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_r,
   output logic [N_MASTERS-1:0]                   m_ack,
   output logic [N_MASTERS-1:0]                   m_err,
   output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]      s_adr,
   output logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_dat_w,
   output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0]  s_sel,
   output logic [N_SLAVES*3-1:0]                  s_cti,
   output logic [N_SLAVES*2-1:0]                  s_bte,
   output logic [N_SLAVES-1:0]                    s_cyc,
   output logic [N_SLAVES-1:0]                    s_stb,
   output logic [N_SLAVES-1:0]                    s_we,
   input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_dat_r,
   input  logic [N_SLAVES-1:0]                    s_ack,
   input  logic [N_SLAVES-1:0]                    s_err
);

   localparam int unsigned AW    = WB_ADDR_WIDTH;
   localparam int unsigned DW    = WB_DATA_WIDTH;
   localparam int unsigned SW    = WB_DATA_WIDTH / 8;
   localparam int unsigned NT    = N_SLAVES + 1;
   localparam int unsigned SID_W = $clog2(N_SLAVES + 1);
   localparam int unsigned MID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StActive} mst_state_e;
   typedef enum logic {ArbFree, ArbBusy} arb_state_e;

   mst_state_e       mst_q [N_MASTERS];
   mst_state_e       mst_d [N_MASTERS];
   logic [SID_W-1:0] sid_q [N_MASTERS];
   logic [SID_W-1:0] sid_d [N_MASTERS];
   logic [SID_W-1:0] dec_sid [N_MASTERS];
   logic [N_MASTERS-1:0] grant_now;

   arb_state_e       arb_q [NT];
   arb_state_e       arb_d [NT];
   logic [MID_W-1:0] gnt_q [NT];
   logic [MID_W-1:0] gnt_d [NT];
   logic [MID_W-1:0] last_q [NT];
   logic [MID_W-1:0] last_d [NT];
   logic [MID_W-1:0] pick [NT];
   logic [N_MASTERS-1:0] req [NT];
   logic [NT-1:0]    pick_vld;
   logic [NT-1:0]    fwd_vld;

   logic             err_tgt_q, err_tgt_d;
   logic [CNT_W-1:0] wd_cnt_q [N_SLAVES];
   logic [CNT_W-1:0] wd_cnt_d [N_SLAVES];
   logic [N_SLAVES-1:0] wd_blk_q, wd_blk_d, wd_to;

   // Address decode; scanning downwards lets the lowest matching index win.
   always_comb begin
      for (int m = 0; m < int'(N_MASTERS); m++) begin
         dec_sid[m] = SID_W'(N_SLAVES);
         for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if (m_adr[m*AW +: AW] >= SLAVE_ADDR_BASE[i*AW +: AW] &&
                m_adr[m*AW +: AW] <= SLAVE_ADDR_LIMIT[i*AW +: AW]) begin
               dec_sid[m] = SID_W'(i);
            end
         end
      end
   end

   // Requests include m_cyc so a dropped cycle frees the arbiter without waiting on the FSM.
   always_comb begin
      for (int t = 0; t < int'(NT); t++) begin
         for (int m = 0; m < int'(N_MASTERS); m++) begin
            req[t][m] = m_cyc[m] && (mst_q[m] != StIdle) && (sid_q[m] == SID_W'(t));
         end
      end
   end

   always_comb begin
      int   idx;
      logic found;
      for (int t = 0; t < int'(NT); t++) begin
         arb_d[t]  = arb_q[t];
         gnt_d[t]  = gnt_q[t];
         last_d[t] = last_q[t];
         found     = 1'b0;
         pick[t]   = '0;
         // Round-robin search starting just above the last grantee, wrapping around.
         for (int k = 1; k <= int'(N_MASTERS); k++) begin
            idx = (int'(last_q[t]) + k) % int'(N_MASTERS);
            if (!found && req[t][idx]) begin
               found   = 1'b1;
               pick[t] = MID_W'(idx);
            end
         end
         pick_vld[t] = found;
         unique case (arb_q[t])
            ArbFree: begin
               if (found) begin
                  arb_d[t]  = ArbBusy;
                  gnt_d[t]  = pick[t];
                  last_d[t] = pick[t];
               end
            end
            ArbBusy: if (!req[t][gnt_q[t]]) arb_d[t] = ArbFree;
            default: arb_d[t] = ArbFree;
         endcase
      end
   end

   always_comb begin
      for (int m = 0; m < int'(N_MASTERS); m++) begin
         grant_now[m] = (mst_q[m] == StReq) && (arb_q[sid_q[m]] == ArbFree) &&
                        pick_vld[sid_q[m]] && (pick[sid_q[m]] == MID_W'(m));
         mst_d[m] = mst_q[m];
         sid_d[m] = sid_q[m];
         unique case (mst_q[m])
            StIdle: begin
               if (m_cyc[m] && m_stb[m]) begin
                  mst_d[m] = StReq;
                  sid_d[m] = dec_sid[m];
               end
            end
            StReq: begin
               if (!m_cyc[m])        mst_d[m] = StIdle;
               else if (grant_now[m]) mst_d[m] = StActive;
            end
            StActive: if (!m_cyc[m]) mst_d[m] = StIdle;
            default:  mst_d[m] = StIdle;
         endcase
      end
   end

   always_comb begin
      for (int t = 0; t < int'(NT); t++) begin
         fwd_vld[t] = (arb_q[t] == ArbBusy) && (mst_q[gnt_q[t]] == StActive);
      end
   end

   // Forward path; a watchdog-blocked slave keeps its address but loses cyc/stb.
   always_comb begin
      int g;
      s_adr = '0; s_dat_w = '0; s_sel = '0; s_cti = '0; s_bte = '0;
      s_cyc = '0; s_stb = '0; s_we = '0;
      for (int s = 0; s < int'(N_SLAVES); s++) begin
         g = int'(gnt_q[s]);
         if (fwd_vld[s]) begin
            s_adr[s*AW +: AW]   = m_adr[g*AW +: AW];
            s_dat_w[s*DW +: DW] = m_dat_w[g*DW +: DW];
            s_sel[s*SW +: SW]   = m_sel[g*SW +: SW];
            s_cti[s*3 +: 3]     = m_cti[g*3 +: 3];
            s_bte[s*2 +: 2]     = m_bte[g*2 +: 2];
            s_we[s]             = m_we[g];
            s_cyc[s]            = m_cyc[g] & ~wd_blk_q[s];
            s_stb[s]            = m_stb[g] & ~wd_blk_q[s];
         end
      end
   end

   always_comb begin
      int g;
      g = int'(gnt_q[N_SLAVES]);
      err_tgt_d = fwd_vld[N_SLAVES] && m_cyc[g] && m_stb[g] && !err_tgt_q;
   end

   // Watchdog: counts unanswered strobe cycles; an ack in the timeout cycle still wins.
   always_comb begin
      int   g;
      logic waiting;
      for (int s = 0; s < int'(N_SLAVES); s++) begin
         g = int'(gnt_q[s]);
         waiting = fwd_vld[s] && m_cyc[g] && m_stb[g] && !s_ack[s] && !s_err[s] &&
                   !wd_blk_q[s];
         wd_to[s]    = (TIMEOUT_CYCLES > 0) && waiting &&
                       (wd_cnt_q[s] == CNT_W'(TIMEOUT_CYCLES));
         wd_cnt_d[s] = wd_cnt_q[s];
         wd_blk_d[s] = wd_blk_q[s];
         if (arb_q[s] != ArbBusy) begin
            wd_cnt_d[s] = '0;
            wd_blk_d[s] = 1'b0;
         end else if (!wd_blk_q[s] && (s_ack[s] || s_err[s])) begin
            wd_cnt_d[s] = '0;
         end else if (wd_to[s]) begin
            wd_blk_d[s] = 1'b1;
         end else if (waiting && (TIMEOUT_CYCLES > 0)) begin
            wd_cnt_d[s] = wd_cnt_q[s] + 1'b1;
         end
      end
   end

   // Return path; only the master in its data phase sees its target's response.
   always_comb begin
      int t;
      m_dat_r = '0; m_ack = '0; m_err = '0;
      for (int m = 0; m < int'(N_MASTERS); m++) begin
         t = int'(sid_q[m]);
         if (mst_q[m] == StActive) begin
            if (t == int'(N_SLAVES)) begin
               m_err[m] = err_tgt_q;
            end else begin
               m_dat_r[m*DW +: DW] = s_dat_r[t*DW +: DW];
               m_ack[m] = s_ack[t] & ~wd_blk_q[t];
               m_err[m] = (s_err[t] & ~wd_blk_q[t]) | wd_to[t];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int m = 0; m < int'(N_MASTERS); m++) begin
            mst_q[m] <= StIdle;
            sid_q[m] <= '0;
         end
         for (int t = 0; t < int'(NT); t++) begin
            arb_q[t]  <= ArbFree;
            gnt_q[t]  <= '0;
            last_q[t] <= MID_W'(N_MASTERS - 1);
         end
         for (int s = 0; s < int'(N_SLAVES); s++) wd_cnt_q[s] <= '0;
         wd_blk_q  <= '0;
         err_tgt_q <= 1'b0;
      end else begin
         for (int m = 0; m < int'(N_MASTERS); m++) begin
            mst_q[m] <= mst_d[m];
            sid_q[m] <= sid_d[m];
         end
         for (int t = 0; t < int'(NT); t++) begin
            arb_q[t]  <= arb_d[t];
            gnt_q[t]  <= gnt_d[t];
            last_q[t] <= last_d[t];
         end
         for (int s = 0; s < int'(N_SLAVES); s++) wd_cnt_q[s] <= wd_cnt_d[s];
         wd_blk_q  <= wd_blk_d;
         err_tgt_q <= err_tgt_d;
      end
   end

endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// Directed bench for wb_interconnect_nxm: 2 masters, 3 slaves, watchdog of 8 cycles.
// Slave map: 0x0000-0x0FFF, 0x1000-0x1FFF, 0x2000-0x2FFF; everything else is unmapped.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_wb_interconnect_nxm;

   localparam int unsigned NM = 2;
   localparam int unsigned NS = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [NM*AW-1:0]    m_adr;
   logic [NM*DW-1:0]    m_dat_w;
   logic [NM*SW-1:0]    m_sel;
   logic [NM*3-1:0]     m_cti;
   logic [NM*2-1:0]     m_bte;
   logic [NM-1:0]       m_cyc, m_stb, m_we;
   logic [NM*DW-1:0]    m_dat_r;
   logic [NM-1:0]       m_ack, m_err;
   logic [NS*AW-1:0]    s_adr;
   logic [NS*DW-1:0]    s_dat_w;
   logic [NS*SW-1:0]    s_sel;
   logic [NS*3-1:0]     s_cti;
   logic [NS*2-1:0]     s_bte;
   logic [NS-1:0]       s_cyc, s_stb, s_we;
   logic [NS*DW-1:0]    s_dat_r;
   logic [NS-1:0]       s_ack, s_err;
   logic [NS-1:0]       ack_en;

   // Zero-wait slave model: ack follows strobe for every enabled slave.
   assign s_ack = s_stb & ack_en;
   assign s_err = '0;

   int n_assert = 0;
   int n_fail   = 0;

   wb_interconnect_nxm #(
      .N_MASTERS       (NM),
      .N_SLAVES        (NS),
      .WB_ADDR_WIDTH   (AW),
      .WB_DATA_WIDTH   (DW),
      .SLAVE_ADDR_BASE ({32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
      .SLAVE_ADDR_LIMIT({32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF}),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m_adr   (m_adr),
      .m_dat_w (m_dat_w),
      .m_sel   (m_sel),
      .m_cti   (m_cti),
      .m_bte   (m_bte),
      .m_cyc   (m_cyc),
      .m_stb   (m_stb),
      .m_we    (m_we),
      .m_dat_r (m_dat_r),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .s_adr   (s_adr),
      .s_dat_w (s_dat_w),
      .s_sel   (s_sel),
      .s_cti   (s_cti),
      .s_bte   (s_bte),
      .s_cyc   (s_cyc),
      .s_stb   (s_stb),
      .s_we    (s_we),
      .s_dat_r (s_dat_r),
      .s_ack   (s_ack),
      .s_err   (s_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic mreq(input int m, input logic [31:0] a, input logic [2:0] cti);
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
      m_we[m]  = 1'b0;
      m_adr[m*AW +: AW] = a;
      m_sel[m*SW +: SW] = 4'hF;
      m_cti[m*3 +: 3]   = cti;
   endtask

   task automatic mdrop(input int m);
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
   endtask

   initial begin
      logic [31:0] baddr;
      logic [2:0]  bcti;
      rst = 1'b1;
      m_adr = '0; m_dat_w = '0; m_sel = '0; m_cti = '0; m_bte = '0;
      m_cyc = '0; m_stb = '0; m_we = '0;
      ack_en  = 3'b111;
      s_dat_r = {32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0A0A};

      // Reset state
      cyc_start();
      cyc_start();
      rst = 1'b0;
      smp();
      chk("reset m_ack", m_ack, 0);
      chk("reset m_err", m_err, 0);
      chk("reset m_dat_r", m_dat_r, 0);
      chk("reset s_cyc", s_cyc, 0);
      chk("reset s_stb", s_stb, 0);

      // Single read: m0 -> slave1, zero-wait ack visible at T+2
      cyc_start(); mreq(0, 32'h0000_1004, 3'b000); smp();
      chk("rd T s_stb", s_stb, 0);
      cyc_start(); smp();
      chk("rd T+1 s_stb", s_stb, 0);
      chk("rd T+1 m_ack", m_ack, 0);
      cyc_start(); smp();
      chk("rd T+2 s_stb", s_stb, 3'b010);
      chk("rd T+2 s_cyc", s_cyc, 3'b010);
      chk("rd T+2 s_adr1", s_adr[63:32], 32'h0000_1004);
      chk("rd T+2 m_ack", m_ack, 2'b01);
      chk("rd T+2 m_dat_r0", m_dat_r[31:0], 32'hDEAD_BEEF);
      chk("rd T+2 m_err", m_err, 0);
      cyc_start(); mdrop(0); smp();
      chk("rd T+3 m_ack", m_ack, 0);
      cyc_start(); cyc_start();

      // Contention on slave0: grants m0, m1, m0 with idle cycles between them
      cyc_start(); mreq(0, 32'h0000_0010, 3'b000); mreq(1, 32'h0000_0020, 3'b000); smp();
      cyc_start(); smp();
      chk("arb T+1 s_stb", s_stb, 0);
      cyc_start(); smp();
      chk("arb g1 m_ack", m_ack, 2'b01);
      chk("arb g1 s_adr0", s_adr[31:0], 32'h0000_0010);
      cyc_start(); mdrop(0); smp();
      chk("arb drop s_stb", s_stb, 0);
      cyc_start(); mreq(0, 32'h0000_0010, 3'b000); smp();
      chk("arb gap s_stb", s_stb, 0);
      chk("arb gap m_ack", m_ack, 0);
      cyc_start(); smp();
      chk("arb g2 m_ack", m_ack, 2'b10);
      chk("arb g2 s_adr0", s_adr[31:0], 32'h0000_0020);
      cyc_start(); mdrop(1); smp();
      chk("arb drop2 m_ack", m_ack, 0);
      cyc_start(); smp();
      chk("arb gap2 s_stb", s_stb, 0);
      cyc_start(); smp();
      chk("arb g3 m_ack", m_ack, 2'b01);
      cyc_start(); mdrop(0);
      cyc_start(); cyc_start();

      // Burst hold on slave2; beats past 0x2FFF still go to the latched slave
      cyc_start(); mreq(0, 32'h0000_2FF8, 3'b010); mreq(1, 32'h0000_2100, 3'b000); smp();
      cyc_start(); smp();
      for (int b = 0; b < 4; b++) begin
         cyc_start();
         baddr = 32'h0000_2FF8 + 32'(4 * b);
         bcti  = (b == 3) ? 3'b111 : 3'b010;
         m_adr[31:0] = baddr;
         m_cti[2:0]  = bcti;
         smp();
         chk("burst s_stb", s_stb, 3'b100);
         chk("burst s_adr2", s_adr[95:64], baddr);
         chk("burst s_cti2", s_cti[8:6], bcti);
         chk("burst m_ack", m_ack, 2'b01);
      end
      cyc_start(); mdrop(0); smp();
      chk("burst drop m_ack", m_ack, 0);
      cyc_start(); smp();
      chk("burst gap s_stb", s_stb, 0);
      cyc_start(); smp();
      chk("burst m1 m_ack", m_ack, 2'b10);
      chk("burst m1 s_adr2", s_adr[95:64], 32'h0000_2100);
      cyc_start(); mdrop(1);
      cyc_start(); cyc_start();

      // Decode error: m1 to unmapped address, err at T+3 only
      cyc_start(); mreq(1, 32'hF000_0000, 3'b000); smp();
      cyc_start(); smp();
      cyc_start(); smp();
      chk("derr T+2 m_err", m_err, 0);
      chk("derr T+2 s_stb", s_stb, 0);
      cyc_start(); smp();
      chk("derr T+3 m_err", m_err, 2'b10);
      chk("derr T+3 m_ack", m_ack, 0);
      chk("derr T+3 s_stb", s_stb, 0);
      cyc_start(); mdrop(1); smp();
      chk("derr T+4 m_err", m_err, 0);
      cyc_start(); cyc_start();

      // Watchdog: slave1 never acks; err after 8 waiting cycles, then stb forced low
      ack_en = 3'b101;
      cyc_start(); mreq(0, 32'h0000_1100, 3'b000); smp();
      cyc_start(); smp();
      for (int i = 0; i < 8; i++) begin
         cyc_start(); smp();
         chk("wd wait s_stb", s_stb, 3'b010);
         chk("wd wait m_err", m_err, 0);
      end
      cyc_start(); smp();
      chk("wd timeout m_err", m_err, 2'b01);
      chk("wd timeout m_ack", m_ack, 0);
      cyc_start(); smp();
      chk("wd blocked s_stb", s_stb, 0);
      chk("wd blocked s_cyc", s_cyc, 0);
      chk("wd blocked m_err", m_err, 0);
      cyc_start(); smp();
      chk("wd blocked2 s_stb", s_stb, 0);
      cyc_start(); mdrop(0);
      cyc_start(); cyc_start();

      // Parallel stalled transfers, then reset mid-transfer
      ack_en = 3'b100;
      cyc_start(); mreq(0, 32'h0000_1200, 3'b000); mreq(1, 32'h0000_0300, 3'b000); smp();
      cyc_start(); smp();
      cyc_start(); smp();
      chk("par s_stb", s_stb, 3'b011);
      chk("par s_cyc", s_cyc, 3'b011);
      cyc_start(); rst = 1'b1; smp();
      cyc_start(); ack_en = 3'b111; smp();
      chk("rst s_cyc", s_cyc, 0);
      chk("rst s_stb", s_stb, 0);
      chk("rst s_adr", s_adr[63:0], 0);
      chk("rst m_ack", m_ack, 0);
      chk("rst m_err", m_err, 0);
      chk("rst m_dat_r", m_dat_r, 0);
      cyc_start(); rst = 1'b0; smp();
      chk("rst release s_stb", s_stb, 0);
      chk("rst release m_ack", m_ack, 0);
      cyc_start(); mdrop(0); mdrop(1);
      cyc_start(); cyc_start();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
